mmcm_drp_reconfig: RTL and testbench

Initiator side of the MMCME3_ADV Dynamic Reconfiguration Port (DRP). On a start request it holds the MMCM in reset and walks a configuration table: for each entry it reads, masks, and writes one DRP register. It then releases reset, waits for lock, and reports done or error. It sits between system control logic and an MMCME3_ADV whose DRP pins (DADDR/DEN/DWE/DI/DO/DRDY) and RST/LOCKED it drives and monitors.

---
 rtl/mmcm_drp_pkg.sv | 35 +++
 rtl/mmcm_drp_reconfig.sv | 229 ++++++++++++++++++++++
 tb/tb_mmcm_drp_reconfig.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmcm_drp_pkg.sv
// Shared types and constants for the MMCM DRP reconfiguration initiator.
// A table entry is {addr[38:32], mask[31:16], data[15:0]}.
package mmcm_drp_pkg;

    localparam int DRP_AW = 7;
    localparam int DRP_DW = 16;

    localparam int ENT_ADDR = 32;
    localparam int ENT_MASK = 16;
    localparam int ENT_DATA = 0;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_DRDY = 2'd1;
    localparam logic [1:0] ERR_LOCK = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HOLD_RST,
        S_FETCH,
        S_READ,
        S_WAIT_RD,
        S_WRITE,
        S_WAIT_WR,
        S_RELEASE,
        S_WAIT_LOCK
    } state_e;

    // Mask bit 1 keeps the bit read back from the MMCM, 0 takes the table bit.
    function automatic logic [DRP_DW-1:0] merge_word(input logic [DRP_DW-1:0] rd,
                                                     input logic [DRP_DW-1:0] mask,
                                                     input logic [DRP_DW-1:0] data);
        return (rd & mask) | (data & ~mask);
    endfunction

endpackage

// File: rtl/mmcm_drp_reconfig.sv
// DRP initiator: holds the MMCM in reset, read-modify-writes each table entry,
// then releases reset and waits for lock, reporting done or a sticky error.
module mmcm_drp_reconfig
    import mmcm_drp_pkg::*;
#(
    parameter int NUM_ENTRIES  = 23,
    parameter int ROM_AW       = 5,
    parameter int RST_HOLD     = 4,
    parameter int DRDY_TIMEOUT = 63,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [38:0]       rom_data,
    output logic [DRP_AW-1:0] daddr,
    output logic              den,
    output logic              dwe,
    output logic [DRP_DW-1:0] di,
    input  logic [DRP_DW-1:0] do_i,
    input  logic              drdy,
    output logic              mmcm_rst,
    input  logic              locked
);

    state_e              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [ROM_AW-1:0]   idx_q, idx_d;
    logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
    logic [DRP_DW-1:0]   mask_q, mask_d;
    logic [DRP_DW-1:0]   wdata_q, wdata_d;
    logic [DRP_AW-1:0]   daddr_q, daddr_d;
    logic [DRP_DW-1:0]   di_q, di_d;
    logic                den_q, den_d;
    logic                dwe_q, dwe_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [1:0]          err_code_q, err_code_d;
    logic                mmcm_rst_q, mmcm_rst_d;
    logic                fin_q, fin_d;
    logic                lock_s1_q, lock_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_s1_q <= 1'b0;
            lock_s2_q <= 1'b0;
        end else begin
            lock_s1_q <= locked;
            lock_s2_q <= lock_s1_q;
        end
    end

    // fin_q marks the done/error cycle so a start landing there is dropped.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        rom_addr_d = rom_addr_q;
        mask_d     = mask_q;
        wdata_d    = wdata_q;
        daddr_d    = daddr_q;
        di_d       = di_q;
        den_d      = 1'b0;
        dwe_d      = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        err_code_d = err_code_q;
        mmcm_rst_d = mmcm_rst_q;
        fin_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !fin_q) begin
                    error_d    = 1'b0;
                    err_code_d = ERR_NONE;
                    busy_d     = 1'b1;
                    mmcm_rst_d = 1'b1;
                    idx_d      = '0;
                    cnt_d      = '0;
                    state_d    = S_HOLD_RST;
                end
            end
            S_HOLD_RST: begin
                if (cnt_q >= 16'(RST_HOLD - 1)) begin
                    cnt_d      = '0;
                    rom_addr_d = idx_q;
                    state_d    = S_FETCH;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_FETCH: begin
                if (cnt_q == 16'd0) begin
                    cnt_d = 16'd1;
                end else begin
                    daddr_d = rom_data[ENT_ADDR +: DRP_AW];
                    mask_d  = rom_data[ENT_MASK +: DRP_DW];
                    wdata_d = rom_data[ENT_DATA +: DRP_DW];
                    den_d   = 1'b1;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                cnt_d   = 16'd1;
                state_d = S_WAIT_RD;
            end
            S_WAIT_RD: begin
                if (drdy) begin
                    di_d    = merge_word(do_i, mask_q, wdata_q);
                    den_d   = 1'b1;
                    dwe_d   = 1'b1;
                    state_d = S_WRITE;
                end else if (cnt_q == 16'(DRDY_TIMEOUT)) begin
                    error_d    = 1'b1;
                    err_code_d = ERR_DRDY;
                    busy_d     = 1'b0;
                    fin_d      = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_WRITE: begin
                cnt_d   = 16'd1;
                state_d = S_WAIT_WR;
            end
            S_WAIT_WR: begin
                if (drdy) begin
                    if (idx_q == ROM_AW'(NUM_ENTRIES - 1)) begin
                        mmcm_rst_d = 1'b0;
                        state_d    = S_RELEASE;
                    end else begin
                        idx_d      = idx_q + ROM_AW'(1);
                        rom_addr_d = idx_q + ROM_AW'(1);
                        cnt_d      = '0;
                        state_d    = S_FETCH;
                    end
                end else if (cnt_q == 16'(DRDY_TIMEOUT)) begin
                    // MMCM stays in reset: its configuration is only partly written.
                    error_d    = 1'b1;
                    err_code_d = ERR_DRDY;
                    busy_d     = 1'b0;
                    fin_d      = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RELEASE: begin
                cnt_d   = 16'd1;
                state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_s2_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    fin_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == 16'(LOCK_TIMEOUT)) begin
                    error_d    = 1'b1;
                    err_code_d = ERR_LOCK;
                    busy_d     = 1'b0;
                    fin_d      = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            rom_addr_q <= '0;
            mask_q     <= '0;
            wdata_q    <= '0;
            daddr_q    <= '0;
            di_q       <= '0;
            den_q      <= 1'b0;
            dwe_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            mmcm_rst_q <= 1'b0;
            fin_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            rom_addr_q <= rom_addr_d;
            mask_q     <= mask_d;
            wdata_q    <= wdata_d;
            daddr_q    <= daddr_d;
            di_q       <= di_d;
            den_q      <= den_d;
            dwe_q      <= dwe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            mmcm_rst_q <= mmcm_rst_d;
            fin_q      <= fin_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign err_code = err_code_q;
    assign rom_addr = rom_addr_q;
    assign daddr    = daddr_q;
    assign den      = den_q;
    assign dwe      = dwe_q;
    assign di       = di_q;
    assign mmcm_rst = mmcm_rst_q;

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// Bench for mmcm_drp_reconfig: ROM and DRP register models, with a scoreboard
// of expected DRP transactions popped on every den.
module tb_mmcm_drp_reconfig;
    import mmcm_drp_pkg::*;

    localparam int NE = 3;
    localparam int AW = 2;
    localparam int RH = 4;
    localparam int DT = 20;
    localparam int LT = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          locked = 1'b0;
    logic          busy, done, error;
    logic [1:0]    err_code;
    logic [AW-1:0] rom_addr;
    logic [38:0]   rom_data = '0;
    logic [6:0]    daddr;
    logic          den, dwe;
    logic [15:0]   di;
    logic [15:0]   do_i = '0;
    logic          drdy = 1'b0;
    logic          mmcm_rst;

    mmcm_drp_reconfig #(
        .NUM_ENTRIES (NE),
        .ROM_AW      (AW),
        .RST_HOLD    (RH),
        .DRDY_TIMEOUT(DT),
        .LOCK_TIMEOUT(LT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .error(error), .err_code(err_code), .rom_addr(rom_addr), .rom_data(rom_data),
        .daddr(daddr), .den(den), .dwe(dwe), .di(di), .do_i(do_i), .drdy(drdy),
        .mmcm_rst(mmcm_rst), .locked(locked)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Configuration table
    logic [38:0] rom_tbl [0:3] = '{
        {7'h08, 16'hF000, 16'h0123},
        {7'h10, 16'h00FF, 16'hAB00},
        {7'h2A, 16'h0000, 16'h5A5A},
        39'h0
    };
    always @(posedge clk) rom_data <= rom_tbl[rom_addr];

    // DRP register model with programmable drdy latency (>= 2) and read drop
    logic [15:0] mem [0:127] = '{default: 16'hFFFF};
    int          drdy_lat = 2;
    int          drop_at = -1;
    int          mdl_rd = 0;
    logic        pend = 1'b0;
    int          pcnt = 0;
    logic        pwe = 1'b0;
    logic [6:0]  paddr = '0;
    logic [15:0] pdi = '0;

    always @(posedge clk) begin
        drdy <= 1'b0;
        if (pend) begin
            if (pcnt <= 1) begin
                drdy <= 1'b1;
                do_i <= mem[paddr];
                if (pwe) mem[paddr] <= pdi;
                pend <= 1'b0;
            end else begin
                pcnt <= pcnt - 1;
            end
        end
        if (den) begin
            if (!dwe) mdl_rd <= mdl_rd + 1;
            if (dwe || mdl_rd != drop_at) begin
                pend  <= 1'b1;
                pcnt  <= drdy_lat - 1;
                pwe   <= dwe;
                paddr <= daddr;
                pdi   <= di;
            end
        end
    end

    // Scoreboard
    typedef struct packed {
        logic        we;
        logic [6:0]  addr;
        logic [15:0] data;
    } txn_t;
    txn_t        exp_q[$];
    logic [15:0] exp_reg [0:127] = '{default: 16'hFFFF};

    task automatic push_entry(input int e, input bit with_write);
        logic [38:0] ent;
        logic [6:0]  a;
        logic [15:0] m, d, w;
        ent = rom_tbl[e];
        a = ent[38:32];
        m = ent[31:16];
        d = ent[15:0];
        exp_q.push_back('{we: 1'b0, addr: a, data: 16'h0});
        if (with_write) begin
            w = (exp_reg[a] & m) | (d & ~m);
            exp_reg[a] = w;
            exp_q.push_back('{we: 1'b1, addr: a, data: w});
        end
    endtask

    task automatic push_all();
        for (int e = 0; e < NE; e++) push_entry(e, 1'b1);
    endtask

    int n_den = 0;
    int n_done = 0;
    int last_den_cyc = 0;

    always @(negedge clk) begin : mon
        txn_t t;
        if (rst_n) begin
            if (den) begin
                last_den_cyc <= cyc;
                n_den <= n_den + 1;
                if (exp_q.size() == 0) begin
                    check_eq("den_unexpected", 32'(daddr), 32'hFFFF_FFFF);
                end else begin
                    t = exp_q.pop_front();
                    check_eq("txn_dwe", 32'(dwe), 32'(t.we));
                    check_eq("txn_daddr", 32'(daddr), 32'(t.addr));
                    if (t.we) check_eq("txn_di", 32'(di), 32'(t.data));
                    check_eq("txn_mmcm_rst", 32'(mmcm_rst), 32'd1);
                end
            end
            if (done) n_done <= n_done + 1;
        end
    end

    // Called just after a rising edge; start is high for exactly one cycle.
    task automatic pulse_start(output int s);
        s = cyc;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_release(input int max, output int rel);
        bit ok = 0;
        rel = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (!mmcm_rst) begin
                ok = 1;
                rel = cyc;
                break;
            end
        end
        check_eq("wait_release_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_end(input int max, output int t_end);
        bit ok = 0;
        t_end = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (done || error) begin
                ok = 1;
                t_end = cyc;
                break;
            end
        end
        check_eq("wait_end_timeout", 32'(ok), 32'd1);
    endtask

    initial begin
        int s, rel, lk, te, base_done;
        bit ok;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_error", 32'(error), 0);
        check_eq("rst_err_code", 32'(err_code), 0);
        check_eq("rst_den", 32'(den), 0);
        check_eq("rst_dwe", 32'(dwe), 0);
        check_eq("rst_daddr", 32'(daddr), 0);
        check_eq("rst_di", 32'(di), 0);
        check_eq("rst_rom_addr", 32'(rom_addr), 0);
        check_eq("rst_mmcm_rst", 32'(mmcm_rst), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Nominal configuration of three entries
        push_all();
        pulse_start(s);
        @(negedge clk);
        check_eq("start_busy", 32'(busy), 1);
        check_eq("start_mmcm_rst", 32'(mmcm_rst), 1);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (den) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        check_eq("first_den_seen", 32'(ok), 1);
        check_eq("first_den_cycle", 32'(cyc), 32'(s + 1 + RH + 2));
        @(posedge clk);
        #1;
        pulse_start(s);
        wait_release(300, rel);
        check_eq("nom_queue_empty", 32'(exp_q.size()), 0);
        check_eq("nom_den_count", 32'(n_den), 6);
        repeat (3) @(posedge clk);
        #1 locked = 1'b1;
        lk = cyc;
        wait_end(50, te);
        check_eq("nom_done", 32'(done), 1);
        check_eq("nom_error", 32'(error), 0);
        check_eq("nom_done_cycle", 32'(te), 32'(lk + 3));
        check_eq("nom_reg08", 32'(mem[7'h08]), 32'hF123);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        locked = 1'b0;
        @(negedge clk);
        check_eq("start_in_done_ignored", 32'(busy), 0);
        @(negedge clk);
        check_eq("start_in_done_no_den", 32'(n_den), 6);

        // drdy never returns for the second read
        base_done = n_done;
        drop_at = mdl_rd + 1;
        push_entry(0, 1'b1);
        push_entry(1, 1'b0);
        @(posedge clk);
        #1;
        pulse_start(s);
        wait_end(200, te);
        check_eq("drdy_to_error", 32'(error), 1);
        check_eq("drdy_to_code", 32'(err_code), 32'(ERR_DRDY));
        check_eq("drdy_to_cycle", 32'(te), 32'(last_den_cyc + DT + 1));
        check_eq("drdy_to_mmcm_rst", 32'(mmcm_rst), 1);
        check_eq("drdy_to_busy", 32'(busy), 0);
        check_eq("drdy_to_no_done", 32'(n_done), 32'(base_done));
        check_eq("drdy_to_queue", 32'(exp_q.size()), 0);
        drop_at = -1;

        // locked held low
        push_all();
        @(posedge clk);
        #1;
        pulse_start(s);
        wait_release(300, rel);
        wait_end(LT + 20, te);
        check_eq("lock_to_error", 32'(error), 1);
        check_eq("lock_to_code", 32'(err_code), 32'(ERR_LOCK));
        check_eq("lock_to_cycle", 32'(te), 32'(rel + 1 + LT));
        check_eq("lock_to_mmcm_rst", 32'(mmcm_rst), 0);
        check_eq("lock_to_busy", 32'(busy), 0);

        // start in the error cycle is dropped; the one a cycle later is taken.
        // That run uses drdy latency exactly at the timeout limit.
        drdy_lat = DT;
        push_all();
        start = 1'b1;
        @(negedge clk);
        check_eq("start_in_err_ignored", 32'(busy), 0);
        check_eq("start_in_err_keeps_err", 32'(error), 1);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check_eq("restart_busy", 32'(busy), 1);
        check_eq("restart_clears_error", 32'(error), 0);
        check_eq("restart_clears_code", 32'(err_code), 0);
        wait_release(800, rel);
        @(posedge clk);
        #1 locked = 1'b1;
        wait_end(50, te);
        check_eq("edge_done", 32'(done), 1);
        check_eq("edge_no_error", 32'(error), 0);
        check_eq("edge_queue", 32'(exp_q.size()), 0);
        @(posedge clk);
        #1 locked = 1'b0;
        drdy_lat = 2;

        // rst_n asserted while waiting for the first write's drdy
        push_all();
        pulse_start(s);
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (den && dwe) begin
                ok = 1;
                break;
            end
        end
        check_eq("mid_write_seen", 32'(ok), 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_den", 32'(den), 0);
        check_eq("mid_rst_mmcm_rst", 32'(mmcm_rst), 0);
        check_eq("mid_rst_busy", 32'(busy), 0);
        check_eq("mid_rst_done", 32'(done), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_idle", 32'(busy), 0);
        @(posedge clk);
        #1;
        push_all();
        pulse_start(s);
        wait_release(300, rel);
        @(posedge clk);
        #1 locked = 1'b1;
        lk = cyc;
        wait_end(50, te);
        check_eq("fresh_done", 32'(done), 1);
        check_eq("fresh_done_cycle", 32'(te), 32'(lk + 3));
        check_eq("fresh_queue", 32'(exp_q.size()), 0);
        check_eq("fresh_reg10", 32'(mem[7'h10]), 32'hABFF);
        check_eq("fresh_reg2a", 32'(mem[7'h2A]), 32'h5A5A);
        @(posedge clk);
        #1 locked = 1'b0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
